// File: rtl/keyboard_fifo_pkg.sv
// Shared keyboard constants: key-code width and default FIFO depth.
// Imported by the keyboard front end and by keyboard_fifo.
package keyboard_fifo_pkg;
  localparam int KB_CODE_W = 16;
  localparam int KB_FIFO_DEPTH_LOG2 = 3;
endpackage

// File: rtl/keyboard_fifo_sync_fifo_core.sv
// Register-array FIFO with occupancy counter.
// A push while full is accepted only when a pop frees a slot the same cycle.
module sync_fifo_core #(
  parameter int W  = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic          full_o,
  output logic          empty_o,
  output logic          push_ok_o,
  output logic [AW:0]   count_o,
  output logic [AW:0]   count_next_o,
  output logic [W-1:0]  head_o
);
  localparam logic [AW:0]   DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   C_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] P_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [W-1:0]  mem_q [2**AW];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, empty;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == DEPTH);
  assign empty   = (cnt_q == '0);
  assign pop_ok  = pop_i & ~empty;
  assign push_ok = push_i & (~full | pop_ok);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push_ok) wp_d = wp_q + P_ONE;
    if (pop_ok)  rp_d = rp_q + P_ONE;
    if (push_ok & ~pop_ok)
      cnt_d = cnt_q + C_ONE;
    else if (~push_ok & pop_ok)
      cnt_d = cnt_q - C_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is deliberately not reset; empty masking hides stale data.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= din_i;
  end

  assign full_o       = full;
  assign empty_o      = empty;
  assign push_ok_o    = push_ok;
  assign count_o      = cnt_q;
  assign count_next_o = cnt_d;
  assign head_o       = mem_q[rp_q];
endmodule

// File: rtl/keyboard_fifo.sv
// Key-code FIFO seen by the CPU: head register, ready,
// sticky overflow and a level interrupt request.
module keyboard_fifo
  import keyboard_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = KB_FIFO_DEPTH_LOG2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KB_CODE_W-1:0] kb_data,
  input  logic                 kb_strobe,
  input  logic                 rd_pop,
  input  logic                 clr_ovf,
  input  logic                 int_enable,
  output logic [KB_CODE_W-1:0] data_out,
  output logic                 ready,
  output logic                 overflow,
  output logic                 intr,
  output logic [DEPTH_LOG2:0]  count
);
  logic                 full, empty, push_ok;
  logic [DEPTH_LOG2:0]  cnt, cnt_next;
  logic [KB_CODE_W-1:0] head;
  logic                 ovf_q, ovf_d;
  logic                 intr_q, intr_d;

  sync_fifo_core #(
    .W  (KB_CODE_W),
    .AW (DEPTH_LOG2)
  ) u_core (
    .clk          (clk),
    .reset        (reset),
    .push_i       (kb_strobe),
    .pop_i        (rd_pop),
    .din_i        (kb_data),
    .full_o       (full),
    .empty_o      (empty),
    .push_ok_o    (push_ok),
    .count_o      (cnt),
    .count_next_o (cnt_next),
    .head_o       (head)
  );

  // A dropped code beats a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (kb_strobe & ~push_ok)
      ovf_d = 1'b1;
    else if (clr_ovf)
      ovf_d = 1'b0;
    intr_d = int_enable & (cnt_next != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      intr_q <= intr_d;
    end
  end

  assign data_out = head & {KB_CODE_W{~empty}};
  assign ready    = ~empty;
  assign overflow = ovf_q;
  assign intr     = intr_q;
  assign count    = cnt;
endmodule

// File: tb/tb_keyboard_fifo.sv
// Directed bench for keyboard_fifo with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_keyboard_fifo;
  localparam int DL    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   kb_data;
  logic          kb_strobe;
  logic          rd_pop;
  logic          clr_ovf;
  logic          int_enable;
  logic [15:0]   data_out;
  logic          ready;
  logic          overflow;
  logic          intr;
  logic [DL:0]   count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [15:0] q[$];
  bit          m_ovf;
  bit          m_intr;

  keyboard_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .kb_data    (kb_data),
    .kb_strobe  (kb_strobe),
    .rd_pop     (rd_pop),
    .clr_ovf    (clr_ovf),
    .int_enable (int_enable),
    .data_out   (data_out),
    .ready      (ready),
    .overflow   (overflow),
    .intr       (intr),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic lit(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Reference model: a plain queue with the FIFO's push/pop rules.
  always @(posedge clk) begin
    bit do_pop, do_push;
    if (reset) begin
      q.delete();
      m_ovf  = 1'b0;
      m_intr = 1'b0;
    end else begin
      do_pop  = rd_pop && q.size() != 0;
      do_push = kb_strobe && (q.size() < DEPTH || do_pop);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(kb_data);
      if (kb_strobe && !do_push) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      m_intr = int_enable && q.size() != 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      lit("m_data_out", data_out, q.size() != 0 ? q[0] : 16'h0);
      lit("m_ready", ready, q.size() != 0);
      lit("m_count", count, q.size());
      lit("m_overflow", overflow, m_ovf);
      lit("m_intr", intr, m_intr);
    end
  end

  task automatic step(input logic s, input logic [15:0] d,
                      input logic p, input logic c);
    kb_strobe = s;
    kb_data   = s ? d : 16'($urandom);
    rd_pop    = p;
    clr_ovf   = c;
    @(posedge clk);
    #1;
    kb_strobe = 1'b0;
    rd_pop    = 1'b0;
    clr_ovf   = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  logic [15:0] seq [6];

  initial begin
    reset = 1'b1; kb_strobe = 1'b0; kb_data = 16'h0;
    rd_pop = 1'b0; clr_ovf = 1'b0; int_enable = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    lit("rst_data", data_out, 16'h0);
    lit("rst_ready", ready, 1'b0);
    lit("rst_count", count, 0);
    lit("rst_intr", intr, 1'b0);
    lit("rst_ovf", overflow, 1'b0);
    pop();
    lit("idle_pop_count", count, 0);
    lit("idle_pop_ready", ready, 1'b0);

    int_enable = 1'b1;
    push(16'h001c);
    lit("single_ready", ready, 1'b1);
    lit("single_data", data_out, 16'h001c);
    lit("single_count", count, 1);
    lit("single_intr", intr, 1'b1);
    pop();
    lit("single_pop_ready", ready, 1'b0);
    lit("single_pop_data", data_out, 16'h0);
    lit("single_pop_intr", intr, 1'b0);

    seq = '{16'h0012, 16'h001c, 16'h00f0, 16'h001c, 16'h00f0, 16'h0012};
    foreach (seq[i]) push(seq[i]);
    for (int i = 0; i < 6; i++) begin
      lit("order_count", count, 6 - i);
      lit("order_data", data_out, seq[i]);
      pop();
    end
    lit("order_empty", count, 0);

    for (int i = 1; i <= 9; i++) push(16'(i));
    lit("full_count", count, 8);
    lit("full_ovf", overflow, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      lit("full_pop_data", data_out, 16'(i));
      pop();
    end
    lit("full_drained", ready, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    lit("clr_ovf", overflow, 1'b0);
    for (int i = 1; i <= 8; i++) push(16'(i));
    step(1'b1, 16'h0009, 1'b0, 1'b1);
    lit("set_beats_clr", overflow, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    lit("clr_again", overflow, 1'b0);

    step(1'b1, 16'h0076, 1'b1, 1'b0);
    lit("fullpp_count", count, 8);
    lit("fullpp_ovf", overflow, 1'b0);
    for (int i = 2; i <= 8; i++) begin
      lit("fullpp_data", data_out, 16'(i));
      pop();
    end
    lit("fullpp_last", data_out, 16'h0076);
    pop();

    step(1'b1, 16'h005a, 1'b1, 1'b0);
    lit("emptypp_count", count, 1);
    lit("emptypp_data", data_out, 16'h005a);
    pop();

    for (int i = 0; i < 20; i++) begin
      push(16'h0100 + 16'(i));
      lit("wrap_data", data_out, 16'h0100 + 16'(i));
      pop();
      lit("wrap_count", count, 0);
    end

    int_enable = 1'b0;
    push(16'h0033);
    lit("inten_off_intr", intr, 1'b0);
    int_enable = 1'b1;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    lit("inten_on_intr", intr, 1'b1);
    pop();

    for (int i = 0; i < 9; i++) push(16'h0200 + 16'(i));
    pop(); pop(); pop();
    lit("pre_rst_count", count, 5);
    lit("pre_rst_ovf", overflow, 1'b1);
    lit("pre_rst_head", data_out, 16'h0203);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    lit("mid_rst_count", count, 0);
    lit("mid_rst_ready", ready, 1'b0);
    lit("mid_rst_intr", intr, 1'b0);
    lit("mid_rst_ovf", overflow, 1'b0);
    lit("mid_rst_data", data_out, 16'h0);
    step(1'b0, 16'h0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keyboard_fifo.md
Name: keyboard_fifo

Overview:
- Buffers 16-bit converted key codes produced by the keyboard block (data + one-cycle strobe) and presents them to the processor side as a readable, poppable register.
- Provides a ready flag, a sticky overflow flag and a level interrupt request.
- Sits directly downstream of keyboard; its outputs feed the bus/IO register decode that the CPU reads.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries); legal range 1..6.

Ports:
- clk  in  1  system clock, same domain as keyboard
- reset  in  1  synchronous, active-high reset
- kb_data  in  16  converted key code from keyboard.data
- kb_strobe  in  1  one-cycle valid pulse from keyboard.strobe
- rd_pop  in  1  one-cycle pulse: CPU has consumed head entry
- clr_ovf  in  1  one-cycle pulse: clear overflow flag
- int_enable  in  1  interrupt enable from CPU control register
- data_out  out  16  head-of-FIFO entry; 16'h0000 when empty
- ready  out  1  FIFO non-empty
- overflow  out  1  sticky: a code was dropped because FIFO was full
- intr  out  1  interrupt request, level
- count  out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2

Behaviour:
- Storage: register array of 2**DEPTH_LOG2 x 16. Write pointer wp, read pointer rp, each DEPTH_LOG2 bits, wrapping modulo depth. Separate occupancy counter cnt of DEPTH_LOG2+1 bits; full = (cnt == 2**DEPTH_LOG2), empty = (cnt == 0).
- Reset (synchronous, wins over everything): wp=0, rp=0, cnt=0, overflow=0, intr=0. Consequently data_out=0, ready=0, count=0. Array contents are not cleared.
- Push (kb_strobe & ~full): mem[wp] <= kb_data, wp++, cnt++.
- Push when full and no pop:
  - code is dropped; overflow <= 1.
  - wp, cnt and contents are unchanged; the oldest entries are preserved.
- Pop (rd_pop & ~empty): rp++, cnt--. rd_pop when empty is ignored with no side effects.
- Simultaneous push and pop:
  - When not empty: both occur and cnt is unchanged.
  - When full: both occur, the new code is accepted and overflow is not set.
  - When empty: the push occurs and the pop is ignored, giving cnt=1.
- Overflow flag:
  - set on a dropped push; cleared by clr_ovf.
  - If set and clear occur in the same cycle, set wins.
- Latency:
  - strobe in cycle N -> ready=1, count updated and data_out = pushed code in cycle N+1 (registered state; data_out = mem[rp] & {16{~empty}}).
  - Pop in cycle N -> data_out shows the next entry (or 0) in cycle N+1.
- Ordering: strict FIFO; codes leave in arrival order with no merging or filtering. Make/break and modifier codes pass through verbatim.
- Interrupt: intr is a register, intr <= int_enable & (next-cycle non-empty). It rises in cycle N+1 after the first push and drops in the cycle after the pop that empties the FIFO. Deasserting int_enable drops intr the next cycle.
- kb_data is sampled only when kb_strobe=1. X on kb_data while kb_strobe=0 must not propagate.
- Pointer wrap: after 2**DEPTH_LOG2 pushes and pops, the pointers return to 0 with no gap or duplication.

Decomposition:
- Shared package/header: KB_CODE_W=16 and the default DEPTH_LOG2, used by keyboard and keyboard_fifo.
- One natural sub-module, sync_fifo_core: parameterised register-array FIFO (push, pop, full, empty, count, head).
- keyboard_fifo wraps sync_fifo_core with the overflow flag, interrupt register and data_out masking.

Test Plan:
- Reset then idle: data_out=0x0000, ready=0, count=0, intr=0, overflow=0. A rd_pop pulse leaves all outputs unchanged.
- Single push with int_enable=1:
  - Push 0x001c at cycle N -> cycle N+1: ready=1, data_out=0x001c, count=1; intr=1 by N+1.
  - rd_pop -> next cycle: ready=0, data_out=0, count=0, then intr=0.
- Ordering: push 0x0012, 0x001c, 0x00f0, 0x001c, 0x00f0, 0x0012 with no pops -> popping yields the exact same sequence and count goes 6..0.
- Full/overflow (depth 8):
  - Push 0x0001..0x0009 -> count=8, overflow=1, and pops yield 0x0001..0x0008 with 0x0009 absent.
  - clr_ovf -> overflow=0.
  - clr_ovf coincident with a dropped push -> overflow stays 1.
- Simultaneous push and pop:
  - When full: push 0x0076 with rd_pop -> count stays 8, overflow stays 0, and 0x0076 emerges last.
  - When empty: push 0x005a with rd_pop -> count=1, data_out=0x005a.
- Wrap and reset mid-operation:
  - 20 push/pop pairs of 0x0100+i -> each pop returns the correct value across pointer wrap.
  - Reset asserted with count=5 -> next cycle count=0, ready=0, intr=0, overflow=0.
